// File: rtl/lhca_pkg.sv
// Shared types and the rule 90/150 null-boundary step function for the LHCA checker.
package lhca_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lhca_state_e;

  localparam logic [7:0] LHCA_RULE_DEFAULT = 8'h06;
  localparam logic [7:0] LHCA_SEED_DEFAULT = 8'h01;
  localparam int         LHCA_MAX_W        = 64;

  // Cells at or above 'width' are masked off, so s[width] reads as zero (null boundary).
  function automatic logic [LHCA_MAX_W-1:0] lhca_next(input logic [LHCA_MAX_W-1:0] s,
                                                      input logic [LHCA_MAX_W-1:0] rule,
                                                      input int width);
    logic [LHCA_MAX_W-1:0] mask;
    logic [LHCA_MAX_W-1:0] sm;
    mask = {LHCA_MAX_W{1'b1}} >> (LHCA_MAX_W - width);
    sm   = s & mask;
    return ((sm << 1) ^ (sm >> 1) ^ (rule & sm)) & mask;
  endfunction

endpackage

// File: rtl/lhca_step.sv
// Combinational one-step LHCA next-state: O = next(I).
module lhca_step import lhca_pkg::*; #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RULE  = WIDTH'(LHCA_RULE_DEFAULT)
) (
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
);

  assign O = WIDTH'(lhca_next(LHCA_MAX_W'(I), LHCA_MAX_W'(RULE), WIDTH));

endmodule

// File: rtl/lhca_checker.sv
// Receive-side LHCA pattern checker: self-seeds from the stream, then flywheels its prediction.
//
// state      | meaning
// SEARCH     | waiting for a non-zero sample to seed the predictor
// ACQUIRE    | counting consecutive matches; any miss reseeds, zero returns to SEARCH
// LOCKED     | flywheeling; misses pulse ERR and bump ERRCOUNT, LOSS_COUNT in a row drops lock
module lhca_checker import lhca_pkg::*; #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RULE       = WIDTH'(LHCA_RULE_DEFAULT),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 3,
  parameter int               ERR_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [WIDTH-1:0]     I,
  input  logic                 VALID,
  input  logic                 CLEAR,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [ERR_WIDTH-1:0] ERRCOUNT,
  output logic [1:0]           STATE
);

  // Counters only need to reach COUNT-1; the terminal value triggers the transition.
  localparam int CNT_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

  lhca_state_e          state_q, state_d;
  logic [WIDTH-1:0]     pred_q, pred_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] errcount_q, errcount_d;
  logic [WIDTH-1:0]     next_i, next_pred;
  logic                 sample_nz, sample_hit, count_err;

  lhca_step #(.WIDTH(WIDTH), .RULE(RULE)) u_step_i    (.I(I),      .O(next_i));
  lhca_step #(.WIDTH(WIDTH), .RULE(RULE)) u_step_pred (.I(pred_q), .O(next_pred));

  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    count_err  = 1'b0;
    sample_nz  = |I;
    sample_hit = (I == pred_q);

    if (VALID) begin
      case (state_q)
        ST_SEARCH: begin
          if (sample_nz) begin
            pred_d  = next_i;
            cnt_d   = '0;
            state_d = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (!sample_nz) begin
            cnt_d   = '0;
            state_d = ST_SEARCH;
          end else if (sample_hit) begin
            pred_d = next_i;
            if (cnt_q == LOCK_LAST) begin
              cnt_d   = '0;
              miss_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            pred_d = next_i;
            cnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          // Never reseed here: the prediction must keep phase through corrupted samples.
          pred_d = next_pred;
          if (sample_hit) begin
            miss_d = '0;
          end else begin
            count_err = 1'b1;
            if (miss_q == MISS_LAST) begin
              miss_d  = '0;
              state_d = ST_SEARCH;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    locked_d   = (state_d == ST_LOCKED);
    err_d      = count_err;
    errcount_d = errcount_q;
    if (CLEAR) errcount_d = '0;
    if (count_err) begin
      if (CLEAR)             errcount_d = ERR_WIDTH'(1);
      else if (!(&errcount_q)) errcount_d = errcount_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_SEARCH;
      pred_q     <= '0;
      cnt_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      errcount_q <= '0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      errcount_q <= errcount_d;
    end
  end

  assign LOCKED   = locked_q;
  assign ERR      = err_q;
  assign ERRCOUNT = errcount_q;
  assign STATE    = state_q;

endmodule

// File: doc/lhca_checker.md
Name: lhca_checker

Overview:
- Receive-side checker for the linear hybrid cellular automaton (rule 90/150, null boundary) pattern generator that drives the board LEDs.
- Takes sampled LHCA states qualified by a valid strobe, acquires lock by self-seeding from the incoming data, then flywheels its own prediction.
- Flags mismatches, keeps a saturating error count and drops lock after repeated misses.
- Sits between a capture register (pins or a loopback from the generator) and status LEDs or debug logic.

Parameters:
WIDTH, 8, cell count / sample width
RULE, 8'h06, bit i=1 -> cell i uses rule 150; bit i=0 -> rule 90 (matches the 8-cell generator)
LOCK_COUNT, 4, consecutive matches in ACQUIRE required to enter LOCKED (>=1)
LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock (>=1)
ERR_WIDTH, 16, width of the error counter

Ports:
CLK  input  1  sole clock, rising edge
RESET  input  1  asynchronous, active-high reset
I  input  WIDTH  sampled LHCA state
VALID  input  1  I is a new sample this cycle
CLEAR  input  1  synchronous clear of ERRCOUNT
LOCKED  output  1  registered; high while FSM is in LOCKED
ERR  output  1  registered one-cycle pulse per mismatch counted in LOCKED
ERRCOUNT  output  ERR_WIDTH  saturating mismatch count
STATE  output  2  0=SEARCH, 1=ACQUIRE, 2=LOCKED

Behaviour:
- Next-state function: next(s)[i] = s[i-1] ^ s[i+1] ^ (RULE[i] & s[i]), with s[-1] = s[WIDTH] = 0.
- Sequence from 0x01 with default RULE: 0x01, 0x02, 0x07, 0x0B.
- 0x00 is a fixed point: never a valid seed, never counted as a match in SEARCH or ACQUIRE.
- Reset (async, immediate): STATE=SEARCH, LOCKED=0, ERR=0, ERRCOUNT=0, pred=0, match and miss counters=0.
- All actions occur only on cycles with VALID=1. With VALID=0, state holds, ERR=0 and only CLEAR acts.
- SEARCH:
  - I!=0: pred<=next(I), cnt<=0, go to ACQUIRE.
  - I==0: stay in SEARCH.
- ACQUIRE:
  - I==pred and I!=0: pred<=next(I), cnt<=cnt+1; go to LOCKED when cnt+1==LOCK_COUNT.
  - Mismatch with I!=0: reseed pred<=next(I), cnt<=0, stay in ACQUIRE.
  - I==0: go to SEARCH.
  - No ERR pulses and no counting in this state.
- LOCKED:
  - pred<=next(pred) on every VALID (flywheel; never reseeded from I).
  - Match: miss<=0.
  - Mismatch: ERR=1 on the next cycle, ERRCOUNT+1 (saturates at all-ones), miss<=miss+1.
  - When miss+1==LOSS_COUNT: go to SEARCH, miss<=0, LOCKED falls on the same edge.
- Latency: LOCKED, STATE and ERR update on the clock edge that samples VALID, so they are visible the following cycle.
- CLEAR:
  - Sets ERRCOUNT<=0.
  - If CLEAR coincides with a counted mismatch, ERRCOUNT<=1 (the error is not lost).
  - CLEAR does not affect the FSM.
- Ports I and VALID are used as-is; synchronisation of asynchronous pins is external.

Decomposition:
- Package lhca_pkg holds:
  - the state enum (SEARCH/ACQUIRE/LOCKED) and its 2-bit encoding;
  - the default rule constant 8'h06 and the default seed constant 8'h01;
  - a pure function lhca_next(s, rule) parameterised on WIDTH.
- One combinational sub-module lhca_step (WIDTH, RULE; I -> O = next(I)) computes next(I) and next(pred). It can be reused later for a parameterised generator.

Test Plan:
1. Reset; feed 0x01, 0x02, 0x07, 0x0B, then the continuing sequence, VALID every 4th cycle -> STATE goes 0->1 after the first sample; LOCKED=1 the cycle after the 5th sample; ERR stays 0; ERRCOUNT=0.
2. While locked, replace one sample with 0xFF, then resume the correct sequence -> single ERR pulse, ERRCOUNT=1, LOCKED stays 1, subsequent samples match (flywheel kept phase).
3. While locked, send 3 consecutive wrong samples -> three ERR pulses, ERRCOUNT=3, LOCKED falls and STATE=0 after the third; resuming a valid stream relocks after LOCK_COUNT+1 samples.
4. Constant I=0x00 with VALID every cycle for 100 cycles -> STATE stays 0, LOCKED=0, ERR never asserts.
5. Assert RESET mid-LOCKED with ERRCOUNT=2, not aligned to CLK -> LOCKED=0, ERRCOUNT=0, STATE=0 immediately, without waiting for a clock edge.
6. With ERR_WIDTH=2, force 5 isolated errors (LOSS_COUNT=3) -> ERRCOUNT saturates at 3; then CLEAR together with a mismatch -> ERRCOUNT=1; CLEAR alone -> 0.
